mac_array_ctrl: RTL

Sequencer for the weight-stationary `mac_array` (row × col PEs). It accepts a job descriptor, runs the full job, and raises `done`. A job is a kernel load of col weight vectors, a settling gap, and then a stream of n_act activation vectors. The block drives SRAM read addresses, aligns each returned word with the array `inst_w` code, and counts results at the array's south edge. It sits between the top-level core controller and the `mac_array`/input-SRAM pair.

---
 rtl/mac_array_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the weight-stationary mac_array: kernel load, settle gap,
// activation stream, then drain until every result vector has left the south edge.
module mac_array_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      n_act,
  input  logic [ADDR_W-1:0]      w_base,
  input  logic [ADDR_W-1:0]      x_base,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [row*bw-1:0]      mem_dout,
  output logic [row*bw-1:0]      array_in_w,
  output logic [1:0]             array_inst_w,
  output logic [psum_bw*col-1:0] array_in_n,
  input  logic [col-1:0]         array_valid,
  output logic [2:0]             dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(col - 1);
  localparam logic [ADDR_W-1:0] GAP_LAST  = ADDR_W'(row + col - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LGAP  = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] phase, phase_nxt;
  logic [ADDR_W-1:0] n_q, w_base_q, x_base_q;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [WD_W-1:0]   wd;
  logic              counted;
  logic              timeout_hit;
  logic              accept;
  logic [1:0]        tag;
  logic              unused_valid;

  // Only the last column matters: it is the final column to emit each vector.
  assign unused_valid = ^array_valid[col-2:0];

  assign accept  = (state == S_IDLE) && start;
  assign counted = array_valid[col-1] && ((state == S_EXEC) || (state == S_DRAIN))
                   && (cnt != n_q);
  assign cnt_nxt = counted ? cnt + ONE : cnt;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase + ONE;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        phase_nxt = '0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (phase == LOAD_LAST) begin
          state_nxt = S_LGAP;
          phase_nxt = '0;
        end
      end
      S_LGAP: begin
        if (phase == GAP_LAST) begin
          state_nxt = (n_q != '0) ? S_EXEC : S_DONE;
          phase_nxt = '0;
        end
      end
      S_EXEC: begin
        if (phase == n_q - ONE) begin
          state_nxt = S_DRAIN;
          phase_nxt = '0;
        end
      end
      S_DRAIN: begin
        phase_nxt = '0;
        // A valid on the expiry edge is counted and wins over the watchdog.
        if (cnt_nxt == n_q) begin
          state_nxt = S_DONE;
        end else if (!counted && (wd == WD_LAST)) begin
          state_nxt   = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE: begin
        phase_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        phase_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_rd    = (state == S_LOAD) || (state == S_EXEC);
    tag       = {state == S_EXEC, state == S_LOAD};
    mem_addr  = '0;
    if (state == S_LOAD) mem_addr = w_base_q + phase;
    if (state == S_EXEC) mem_addr = x_base_q + phase;
    dbg_state = state;
  end

  assign array_in_n = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      phase        <= '0;
      n_q          <= '0;
      w_base_q     <= '0;
      x_base_q     <= '0;
      cnt          <= '0;
      wd           <= '0;
      err          <= 1'b0;
      array_in_w   <= '0;
      array_inst_w <= 2'b00;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      array_in_w   <= mem_dout;
      array_inst_w <= tag;
      if (accept) begin
        n_q      <= n_act;
        w_base_q <= w_base;
        x_base_q <= x_base;
        cnt      <= '0;
        wd       <= '0;
        err      <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (counted)               wd <= '0;
        else if (state == S_DRAIN) wd <= wd + WD_W'(1);
        if (timeout_hit)           err <= 1'b1;
      end
    end
  end

endmodule
